jtag_tap_target: RTL and testbench

Parametrised JTAG TAP target: full 16-state IEEE 1149.1 TAP controller with an instruction register and three selectable data registers (bypass, user-defined test-vector register, boundary-scan register). Successor to the fixed 5-bit instruction / fixed-width test-vector arrangement, with configurable instruction, test-vector and boundary-scan widths. Used as the DUT-side responder behind the JTAG master agent, and as the reference model target in slave-side environments.

---
 rtl/jtag_tap_target.sv | 144 ++++++++++++++
 tb/tb_jtag_tap_target.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_target.sv
// JTAG TAP target: 16-state TAP controller with an instruction register and
// bypass, user test-vector and boundary-scan data registers.
module jtag_tap_target #(
  parameter int unsigned INSTR_WIDTH       = 5,
  parameter int unsigned TEST_VECTOR_WIDTH = 32,
  parameter int unsigned BSR_WIDTH         = 16,
  parameter logic [4:0]  BYPASS_OPCODE     = 5'b00000,
  parameter logic [4:0]  USER_OPCODE       = 5'b00001,
  parameter logic [4:0]  BSR_OPCODE        = 5'b00110
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tms,
  input  logic                         tdi,
  output logic                         tdo,
  output logic                         tdoEnable,
  output logic [3:0]                   tapState,
  output logic [INSTR_WIDTH-1:0]       instructionReg,
  input  logic [TEST_VECTOR_WIDTH-1:0] userRegIn,
  output logic [TEST_VECTOR_WIDTH-1:0] userRegOut,
  input  logic [BSR_WIDTH-1:0]         bsrIn,
  output logic [BSR_WIDTH-1:0]         bsrOut,
  output logic                         updateDrPulse
);

  localparam int unsigned OPCODE_WIDTH = 5;

  typedef enum logic [3:0] {
    ST_RESET      = 4'd0,
    ST_IDLE       = 4'd1,
    ST_DR_SCAN    = 4'd2,
    ST_IR_SCAN    = 4'd3,
    ST_CAPTURE_IR = 4'd4,
    ST_SHIFT_IR   = 4'd5,
    ST_EXIT1_IR   = 4'd6,
    ST_PAUSE_IR   = 4'd7,
    ST_EXIT2_IR   = 4'd8,
    ST_UPDATE_IR  = 4'd9,
    ST_CAPTURE_DR = 4'd10,
    ST_SHIFT_DR   = 4'd11,
    ST_EXIT1_DR   = 4'd12,
    ST_PAUSE_DR   = 4'd13,
    ST_EXIT2_DR   = 4'd14,
    ST_UPDATE_DR  = 4'd15
  } tap_state_t;

  tap_state_t                   state;
  tap_state_t                   next_state;
  logic [INSTR_WIDTH-1:0]       ir_shift;
  logic [TEST_VECTOR_WIDTH-1:0] user_shift;
  logic [BSR_WIDTH-1:0]         bsr_shift;
  logic                         bypass_reg;
  logic [OPCODE_WIDTH-1:0]      opcode;
  logic                         sel_user;
  logic                         sel_bsr;

  // TAP state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RESET;
    else        state <= next_state;
  end

  // TAP next-state decode
  always_comb begin
    next_state = state;
    unique case (state)
      ST_RESET:      next_state = tms ? ST_RESET    : ST_IDLE;
      ST_IDLE:       next_state = tms ? ST_DR_SCAN  : ST_IDLE;
      ST_DR_SCAN:    next_state = tms ? ST_IR_SCAN  : ST_CAPTURE_DR;
      ST_IR_SCAN:    next_state = tms ? ST_RESET    : ST_CAPTURE_IR;
      ST_CAPTURE_IR: next_state = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR:   next_state = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR:   next_state = tms ? ST_UPDATE_IR : ST_PAUSE_IR;
      ST_PAUSE_IR:   next_state = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR:   next_state = tms ? ST_UPDATE_IR : ST_SHIFT_IR;
      ST_UPDATE_IR:  next_state = tms ? ST_DR_SCAN  : ST_IDLE;
      ST_CAPTURE_DR: next_state = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR:   next_state = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR:   next_state = tms ? ST_UPDATE_DR : ST_PAUSE_DR;
      ST_PAUSE_DR:   next_state = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR:   next_state = tms ? ST_UPDATE_DR : ST_SHIFT_DR;
      ST_UPDATE_DR:  next_state = tms ? ST_DR_SCAN  : ST_IDLE;
    endcase
  end

  assign tapState = state;

  // Data register select; user wins if two opcodes are configured equal
  assign opcode   = OPCODE_WIDTH'(instructionReg);
  assign sel_user = (opcode == USER_OPCODE);
  assign sel_bsr  = (opcode == BSR_OPCODE) && !sel_user;

  // Capture / shift / update datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instructionReg <= INSTR_WIDTH'(BYPASS_OPCODE);
      ir_shift       <= '0;
      user_shift     <= '0;
      bsr_shift      <= '0;
      bypass_reg     <= 1'b0;
      tdo            <= 1'b0;
      tdoEnable      <= 1'b0;
      userRegOut     <= '0;
      bsrOut         <= '0;
      updateDrPulse  <= 1'b0;
    end else begin
      tdoEnable     <= (state == ST_SHIFT_IR) || (state == ST_SHIFT_DR);
      updateDrPulse <= (state == ST_UPDATE_DR);
      case (state)
        ST_RESET:      instructionReg <= INSTR_WIDTH'(BYPASS_OPCODE);
        ST_CAPTURE_IR: ir_shift <= INSTR_WIDTH'(2'b01);
        ST_SHIFT_IR: begin
          ir_shift <= INSTR_WIDTH'({tdi, ir_shift} >> 1);
          tdo      <= ir_shift[0];
        end
        ST_UPDATE_IR:  instructionReg <= ir_shift;
        ST_CAPTURE_DR: begin
          if (sel_user)     user_shift <= userRegIn;
          else if (sel_bsr) bsr_shift  <= bsrIn;
          else              bypass_reg <= 1'b0;
        end
        ST_SHIFT_DR: begin
          // Concatenate-then-shift keeps a 1-bit register legal
          if (sel_user) begin
            user_shift <= TEST_VECTOR_WIDTH'({tdi, user_shift} >> 1);
            tdo        <= user_shift[0];
          end else if (sel_bsr) begin
            bsr_shift <= BSR_WIDTH'({tdi, bsr_shift} >> 1);
            tdo       <= bsr_shift[0];
          end else begin
            bypass_reg <= tdi;
            tdo        <= bypass_reg;
          end
        end
        ST_UPDATE_DR: begin
          if (sel_user)     userRegOut <= user_shift;
          else if (sel_bsr) bsrOut     <= bsr_shift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_target.sv
// Directed bench for jtag_tap_target: expected tdo bits and update events are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_jtag_tap_target;

  logic        clk = 1'b0;
  logic        reset;
  logic        tms;
  logic        tdi;
  logic        tdo;
  logic        tdoEnable;
  logic [3:0]  tapState;
  logic [4:0]  instructionReg;
  logic [31:0] userRegIn;
  logic [31:0] userRegOut;
  logic [15:0] bsrIn;
  logic [15:0] bsrOut;
  logic        updateDrPulse;

  typedef struct packed {
    logic [31:0] user;
    logic [15:0] bsr;
  } upd_t;

  logic exp_tdo[$];
  upd_t exp_upd[$];
  int   vectors = 0;
  int   miscompares = 0;

  jtag_tap_target #(
    .INSTR_WIDTH(5), .TEST_VECTOR_WIDTH(32), .BSR_WIDTH(16),
    .BYPASS_OPCODE(5'b00000), .USER_OPCODE(5'b00001), .BSR_OPCODE(5'b00110)
  ) dut (
    .clk(clk), .reset(reset), .tms(tms), .tdi(tdi), .tdo(tdo),
    .tdoEnable(tdoEnable), .tapState(tapState), .instructionReg(instructionReg),
    .userRegIn(userRegIn), .userRegOut(userRegOut), .bsrIn(bsrIn),
    .bsrOut(bsrOut), .updateDrPulse(updateDrPulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Monitor: consume one expectation per presented tdo bit / update pulse
  always @(negedge clk) begin
    logic e;
    upd_t u;
    if (tdoEnable) begin
      vectors++;
      if (exp_tdo.size() == 0) begin
        miscompares++;
        $display("FAIL tdo_unexpected: got tdo=%0d with tdoEnable, expected no shift output", tdo);
      end else begin
        e = exp_tdo.pop_front();
        if (tdo !== e) begin
          miscompares++;
          $display("FAIL tdo_bit: got %0d expected %0d (state %0d)", tdo, e, tapState);
        end
      end
    end
    if (updateDrPulse) begin
      vectors++;
      if (exp_upd.size() == 0) begin
        miscompares++;
        $display("FAIL update_pulse_unexpected: got pulse expected none");
      end else begin
        u = exp_upd.pop_front();
        if (userRegOut !== u.user || bsrOut !== u.bsr) begin
          miscompares++;
          $display("FAIL update_values: got user=%h bsr=%h expected user=%h bsr=%h",
                   userRegOut, bsrOut, u.user, u.bsr);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge clk);
    #1;
  endtask

  // From Idle: load an instruction; the captured 2'b01 pattern comes out on tdo
  task automatic ir_scan(input logic [4:0] v);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    exp_tdo.push_back(1'b1);
    for (int i = 0; i < 4; i++) exp_tdo.push_back(1'b0);
    for (int i = 0; i < 5; i++) step(i == 4, v[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  // From Idle: n-bit DR scan, optional pause after bit pause_after
  task automatic dr_scan(input int n, input logic [63:0] din, input int pause_after,
                         input int pause_len);
    bit brk;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      brk = (i == pause_after - 1) && (i != n - 1);
      step((i == n - 1) || brk, din[i]);
      if (brk) begin
        step(1'b0, 1'b0);
        repeat (pause_len - 1) step(1'b0, 1'b0);
        check("pause_state", 64'(tapState), 64'd13);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
      end
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0]  seq;
    int          len;
    logic [31:0] uv;
    logic [15:0] bv;
    logic [7:0]  bp_exp;

    reset = 1'b0; tms = 1'b0; tdi = 1'b0;
    userRegIn = 32'h0; bsrIn = 16'h0;
    #12;
    check("rst_state", 64'(tapState), 64'd0);
    check("rst_ir", 64'(instructionReg), 64'd0);
    check("rst_tdo", 64'({tdo, tdoEnable, updateDrPulse}), 64'd0);
    check("rst_user", 64'(userRegOut), 64'd0);
    check("rst_bsr", 64'(bsrOut), 64'd0);
    #10 reset = 1'b1;

    // Five tms=1 edges from every state reach Reset; one tms=0 reaches Idle
    step(1'b0, 1'b0);
    for (int s = 0; s < 16; s++) begin
      case (s)
        0:  begin seq = 8'b111;     len = 3; end
        1:  begin seq = 8'b0;       len = 1; end
        2:  begin seq = 8'b10;      len = 2; end
        3:  begin seq = 8'b110;     len = 3; end
        4:  begin seq = 8'b0110;    len = 4; end
        5:  begin seq = 8'b00110;   len = 5; end
        6:  begin seq = 8'b10110;   len = 5; end
        7:  begin seq = 8'b010110;  len = 6; end
        8:  begin seq = 8'b1010110; len = 7; end
        9:  begin seq = 8'b110110;  len = 6; end
        10: begin seq = 8'b010;     len = 3; end
        11: begin seq = 8'b0010;    len = 4; end
        12: begin seq = 8'b1010;    len = 4; end
        13: begin seq = 8'b01010;   len = 5; end
        14: begin seq = 8'b101010;  len = 6; end
        default: begin seq = 8'b11010; len = 5; end
      endcase
      for (int i = 0; i < len; i++) step(seq[i], 1'b0);
      check($sformatf("nav_state_%0d", s), 64'(tapState), 64'(s));
      if (s == 5)  exp_tdo.push_back(1'b1);
      if (s == 11) exp_tdo.push_back(1'b0);
      if (s >= 10) exp_upd.push_back('{user: 32'h0, bsr: 16'h0});
      repeat (5) step(1'b1, 1'b0);
      check($sformatf("five_tms_reset_%0d", s), 64'(tapState), 64'd0);
      step(1'b0, 1'b0);
      check($sformatf("to_idle_%0d", s), 64'(tapState), 64'd1);
      check($sformatf("ir_bypass_%0d", s), 64'(instructionReg), 64'd0);
    end

    // IR scan selecting USER (leading tms=0 stays in Idle)
    step(1'b0, 1'b0);
    ir_scan(5'b00001);
    check("ir_user", 64'(instructionReg), 64'h01);
    check("ir_idle", 64'(tapState), 64'd1);

    // User DR scan
    uv = 32'hA5A5_0F0F;
    userRegIn = uv;
    for (int i = 0; i < 32; i++) exp_tdo.push_back(uv[i]);
    exp_upd.push_back('{user: 32'h1234_5678, bsr: 16'h0});
    dr_scan(32, 64'h1234_5678, 0, 0);
    check("user_out", 64'(userRegOut), 64'h1234_5678);

    // Bypass with an unassigned opcode
    ir_scan(5'b11111);
    check("ir_ones", 64'(instructionReg), 64'h1F);
    bp_exp = 8'b1001_1010;  // tdo 0,1,0,1,1,0,0,1 LSB first
    for (int i = 0; i < 8; i++) exp_tdo.push_back(bp_exp[i]);
    exp_upd.push_back('{user: 32'h1234_5678, bsr: 16'h0});
    dr_scan(8, 64'h4D, 0, 0);
    check("bypass_user_hold", 64'(userRegOut), 64'h1234_5678);
    check("bypass_bsr_hold", 64'(bsrOut), 64'h0);

    // Boundary scan with a pause mid-shift
    ir_scan(5'b00110);
    check("ir_bsr", 64'(instructionReg), 64'h06);
    bv = 16'hBEEF;
    bsrIn = bv;
    for (int i = 0; i < 16; i++) exp_tdo.push_back(bv[i]);
    exp_upd.push_back('{user: 32'h1234_5678, bsr: 16'h1357});
    dr_scan(16, 64'h1357, 8, 3);
    check("bsr_out", 64'(bsrOut), 64'h1357);
    check("bsr_user_hold", 64'(userRegOut), 64'h1234_5678);

    // Async reset mid user scan: abort with no update
    ir_scan(5'b00001);
    uv = 32'hCAFE_F00D;
    userRegIn = uv;
    for (int i = 0; i < 10; i++) exp_tdo.push_back(uv[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("arst_state", 64'(tapState), 64'd0);
    check("arst_ir", 64'(instructionReg), 64'd0);
    check("arst_user", 64'(userRegOut), 64'd0);
    check("arst_bsr", 64'(bsrOut), 64'd0);
    check("arst_tdoen", 64'({tdoEnable, updateDrPulse}), 64'd0);
    #20;
    check("arst_hold", 64'(tapState), 64'd0);
    reset = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    check("arst_idle", 64'(tapState), 64'd1);
    check("arst_user_after", 64'(userRegOut), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    check("tdo_queue_drained", 64'(exp_tdo.size()), 64'd0);
    check("upd_queue_drained", 64'(exp_upd.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
